// File: rtl/dmem_dump_if.sv
// ---------------------------------------------------------------------------
// dmem_dump_if -- bundle of the dump engine's control, memory-read and
// byte-stream signals.
//
//   start       host -> engine  one-cycle dump request
//   base_addr   host -> engine  first word address (latched with start)
//   word_count  host -> engine  number of words (latched with start)
//   mem_rd      engine -> mem   synchronous read strobe
//   mem_addr    engine -> mem   read word address
//   mem_rdata   mem -> engine   read data, valid the cycle after mem_rd
//   out_valid   engine -> sink  out_data holds a byte
//   out_data    engine -> sink  streamed byte
//   out_ready   sink -> engine  sink accepts the byte this cycle
//   busy        engine -> host  high outside IDLE
//   done        engine -> host  one-cycle completion pulse
//
// Modport master is the engine side; modport slave is the host/memory/sink side.
// ---------------------------------------------------------------------------
interface dmem_dump_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, word_count, mem_rdata, out_ready,
        output mem_rd, mem_addr, out_valid, out_data, busy, done
    );

    modport slave (
        output start, base_addr, word_count, mem_rdata, out_ready,
        input  mem_rd, mem_addr, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/dmem_dump.sv
// ---------------------------------------------------------------------------
// dmem_dump -- sequential data-memory read-out engine.
//
// Reads word_count words starting at base_addr from a synchronous-read data
// memory and streams each word out least-significant byte first over a
// valid/ready byte interface. Addresses wrap modulo 2^ADDR_W.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset (aborts any dump in progress)
//   io_dump  dmem_dump_if.master: start/base_addr/word_count request,
//            mem_rd/mem_addr/mem_rdata memory port, out_valid/out_data/
//            out_ready byte stream, busy/done status
//
// Optional feature: define DMEM_DUMP_CKSUM_EN to append one byte holding
// the XOR of all data bytes after the last data byte (a zero-count dump
// then emits just 0x00). Without it the stream carries data bytes only.
//
// All outputs are registered; out_ready only feeds state/register updates.
// ---------------------------------------------------------------------------
module dmem_dump #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_dump_if.master   io_dump
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_W:0]   REM_ZERO = '0;
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_SEND  = 3'd3,
`ifdef DMEM_DUMP_CKSUM_EN
        S_CKSUM = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W:0]   r_remain;
    logic [IDX_W-1:0]  r_byte_idx;
    logic [DATA_W-1:0] r_shift;
    logic [7:0]        r_cksum;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic              r_busy;
    logic              r_done;

    logic              w_xfer;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [7:0]        w_cksum_nxt;

    // The shift register drops the byte just sent, so the next byte to
    // present is always in the low 8 bits.
    assign w_xfer      = r_out_valid & io_dump.out_ready;
    assign w_shift_nxt = r_shift >> 8;
    assign w_cksum_nxt = r_cksum ^ r_out_data;

    // Dump FSM with all outputs registered on state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remain    <= '0;
            r_byte_idx  <= '0;
            r_shift     <= '0;
            r_cksum     <= 8'h00;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (io_dump.start) begin
                        r_cur_addr <= io_dump.base_addr;
                        r_remain   <= io_dump.word_count;
                        r_byte_idx <= '0;
                        r_cksum    <= 8'h00;
                        r_busy     <= 1'b1;
                        if (io_dump.word_count == REM_ZERO) begin
`ifdef DMEM_DUMP_CKSUM_EN
                            // Empty dump still emits the (zero) checksum.
                            r_state     <= S_CKSUM;
                            r_out_valid <= 1'b1;
                            r_out_data  <= 8'h00;
`else
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state    <= S_READ;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= io_dump.base_addr;
                        end
                    end
                end
                S_READ: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= S_LATCH;
                end
                S_LATCH: begin
                    r_shift     <= io_dump.mem_rdata;
                    r_out_valid <= 1'b1;
                    r_out_data  <= io_dump.mem_rdata[7:0];
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_cksum <= w_cksum_nxt;
                        if (r_byte_idx == LAST_IDX) begin
                            r_byte_idx <= '0;
                            r_remain   <= r_remain - REM_ONE;
                            r_cur_addr <= r_cur_addr + ADDR_ONE;
                            if (r_remain == REM_ONE) begin
`ifdef DMEM_DUMP_CKSUM_EN
                                // Valid stays high; the checksum byte follows.
                                r_state    <= S_CKSUM;
                                r_out_data <= w_cksum_nxt;
`else
                                r_state     <= S_DONE;
                                r_out_valid <= 1'b0;
                                r_done      <= 1'b1;
`endif
                            end else begin
                                r_state     <= S_READ;
                                r_out_valid <= 1'b0;
                                r_mem_rd    <= 1'b1;
                                r_mem_addr  <= r_cur_addr + ADDR_ONE;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + IDX_ONE;
                            r_shift    <= w_shift_nxt;
                            r_out_data <= w_shift_nxt[7:0];
                        end
                    end
                end
`ifdef DMEM_DUMP_CKSUM_EN
                S_CKSUM: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_rd    <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign io_dump.mem_rd    = r_mem_rd;
    assign io_dump.mem_addr  = r_mem_addr;
    assign io_dump.out_valid = r_out_valid;
    assign io_dump.out_data  = r_out_data;
    assign io_dump.busy      = r_busy;
    assign io_dump.done      = r_done;
endmodule

// File: tb/tb_dmem_dump.sv
// ---------------------------------------------------------------------------
// tb_dmem_dump -- self-checking bench for dmem_dump. A behavioural memory
// answers reads; expected byte streams, address sequences and cycle counts
// are derived from the memory contents and the dump parameters.
// ---------------------------------------------------------------------------
module tb_dmem_dump;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
`ifdef DMEM_DUMP_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dump_if ();

    dmem_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .io_dump (dump_if.master)
    );

    logic [31:0] mem [0:1023];

    // Synchronous-read data memory.
    always @(posedge clk) begin
        if (dump_if.mem_rd) dump_if.mem_rdata <= mem[dump_if.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] q_bytes[$];
    int         q_byte_cyc[$];
    logic [9:0] q_addrs[$];
    int done_cnt, done_cyc, stall_err, busy_cnt, mem_rd_cnt;

    logic [7:0] exp_bytes[$];
    logic [9:0] exp_addrs[$];

    // Reference: words in address order (wrapping), bytes LSB first, optional XOR byte.
    task automatic model_dump(input int base, input int count);
        logic [7:0] x;
        logic [31:0] word;
        int a;
        exp_bytes.delete();
        exp_addrs.delete();
        x = 8'h00;
        for (int w = 0; w < count; w++) begin
            a = (base + w) % 1024;
            exp_addrs.push_back(10'(a));
            word = mem[a];
            for (int b = 0; b < 4; b++) begin
                exp_bytes.push_back(8'((word >> (8 * b)) & 32'hFF));
                x = x ^ 8'((word >> (8 * b)) & 32'hFF);
            end
        end
        if (CK == 1) exp_bytes.push_back(x);
    endtask

    // Drives one dump and records what the DUT does; cycle 0 is the start cycle.
    task automatic run_dump(input int base, input int count, input int ready_mode,
                            input int extra_start_at, input int abort_at);
        int cyc;
        logic rdy, prev_stall;
        logic [7:0] prev_data;
        q_bytes.delete(); q_byte_cyc.delete(); q_addrs.delete();
        done_cnt = 0; done_cyc = -1; stall_err = 0; busy_cnt = 0; mem_rd_cnt = 0;
        prev_stall = 1'b0; prev_data = 8'h00;
        @(negedge clk);
        dump_if.base_addr  = 10'(base);
        dump_if.word_count = 11'(count);
        dump_if.start      = 1'b1;
        cyc = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == extra_start_at) begin
                dump_if.start      = 1'b1;
                dump_if.base_addr  = 10'($urandom_range(0, 1023));
                dump_if.word_count = 11'd1;
            end else begin
                dump_if.start = 1'b0;
            end
            if (abort_at > 0 && q_bytes.size() == abort_at) begin
                rst = 1'b0;
                break;
            end
            if (ready_mode == 0)      rdy = 1'b1;
            else if (ready_mode == 1) rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else                      rdy = 1'($urandom_range(0, 1));
            dump_if.out_ready = rdy;
            if (prev_stall && (!dump_if.out_valid || dump_if.out_data !== prev_data)) stall_err++;
            if (dump_if.mem_rd) begin mem_rd_cnt++; q_addrs.push_back(dump_if.mem_addr); end
            if (dump_if.busy) busy_cnt++;
            if (dump_if.done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (dump_if.out_valid && rdy) begin
                q_bytes.push_back(dump_if.out_data);
                q_byte_cyc.push_back(cyc);
            end
            prev_stall = dump_if.out_valid && !rdy;
            prev_data  = dump_if.out_data;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        dump_if.start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({dump_if.mem_rd, dump_if.mem_addr, dump_if.out_valid, dump_if.out_data,
             dump_if.busy, dump_if.done} !== 22'd0) begin
            errors++; $display("FAIL reset_initial: outputs not idle under reset");
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem[5] = 32'h11223344;
        run_dump(5, 2, 0, 0, 1);
        #1;
        checks++;
        if ({dump_if.mem_rd, dump_if.mem_addr, dump_if.out_valid, dump_if.out_data,
             dump_if.busy, dump_if.done} !== 22'd0) begin
            errors++; $display("FAIL reset_async: outputs busy=%0b valid=%0b data=%h, required all 0",
                               dump_if.busy, dump_if.out_valid, dump_if.out_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({dump_if.mem_rd, dump_if.out_valid, dump_if.busy, dump_if.done} !== 4'd0) begin
                errors++; $display("FAIL reset_idle cycle %0d: rd=%0b valid=%0b busy=%0b done=%0b, required 0",
                                   c, dump_if.mem_rd, dump_if.out_valid, dump_if.busy, dump_if.done);
            end
        end
    endtask

    task automatic test_single_word();
        mem[5] = 32'h11223344;
        model_dump(5, 1);
        run_dump(5, 1, 0, 0, 0);
        checks++;
        if (q_bytes.size() !== exp_bytes.size()) begin
            errors++; $display("FAIL single_len: got %0d bytes, required %0d", q_bytes.size(), exp_bytes.size());
        end
        for (int i = 0; i < exp_bytes.size() && i < q_bytes.size(); i++) begin
            checks++;
            if (q_bytes[i] !== exp_bytes[i] || q_byte_cyc[i] !== 3 + i) begin
                errors++; $display("FAIL single_byte[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                                   i, q_bytes[i], q_byte_cyc[i], exp_bytes[i], 3 + i);
            end
        end
        checks++;
        if (done_cyc !== 7 + CK || done_cnt !== 1) begin
            errors++; $display("FAIL single_done: cycle %0d count %0d, required cycle %0d count 1",
                               done_cyc, done_cnt, 7 + CK);
        end
        checks++;
        if (busy_cnt !== 7 + CK) begin
            errors++; $display("FAIL single_busy: busy %0d cycles, required %0d", busy_cnt, 7 + CK);
        end
        checks++;
        if (q_addrs.size() !== 1 || q_addrs[0] !== 10'd5) begin
            errors++; $display("FAIL single_addr: %0d reads first %h, required 1 read at 005", q_addrs.size(), q_addrs[0]);
        end
    endtask

    task automatic test_backpressure();
        mem[5] = 32'h11223344;
        model_dump(5, 1);
        run_dump(5, 1, 1, 0, 0);
        checks++;
        if (q_bytes.size() !== exp_bytes.size()) begin
            errors++; $display("FAIL bp_len: got %0d bytes, required %0d", q_bytes.size(), exp_bytes.size());
        end
        for (int i = 0; i < exp_bytes.size() && i < q_bytes.size(); i++) begin
            checks++;
            if (q_bytes[i] !== exp_bytes[i]) begin
                errors++; $display("FAIL bp_byte[%0d]: got %h, required %h", i, q_bytes[i], exp_bytes[i]);
            end
        end
        checks++;
        if (stall_err !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL bp_stable: %0d unstable stalls, %0d done, required 0 and 1", stall_err, done_cnt);
        end
    endtask

    task automatic test_wrap();
        mem[10'h3FF] = 32'hA5A5A5A5;
        mem[0]       = 32'h01020304;
        model_dump(10'h3FF, 2);
        run_dump(10'h3FF, 2, 0, 0, 0);
        checks++;
        if (q_addrs.size() !== 2) begin
            errors++; $display("FAIL wrap_reads: got %0d reads, required 2", q_addrs.size());
        end
        for (int i = 0; i < 2 && i < q_addrs.size(); i++) begin
            checks++;
            if (q_addrs[i] !== exp_addrs[i]) begin
                errors++; $display("FAIL wrap_addr[%0d]: got %h, required %h", i, q_addrs[i], exp_addrs[i]);
            end
        end
        checks++;
        if (q_bytes.size() !== exp_bytes.size()) begin
            errors++; $display("FAIL wrap_len: got %0d bytes, required %0d", q_bytes.size(), exp_bytes.size());
        end
        for (int i = 0; i < exp_bytes.size() && i < q_bytes.size(); i++) begin
            checks++;
            if (q_bytes[i] !== exp_bytes[i]) begin
                errors++; $display("FAIL wrap_byte[%0d]: got %h, required %h", i, q_bytes[i], exp_bytes[i]);
            end
        end
        checks++;
        if (done_cyc !== 13 + CK) begin
            errors++; $display("FAIL wrap_done: cycle %0d, required %0d", done_cyc, 13 + CK);
        end
    endtask

    task automatic test_zero_count();
        model_dump(0, 0);
        run_dump(7, 0, 0, 0, 0);
        checks++;
        if (done_cyc !== 1 + CK || done_cnt !== 1) begin
            errors++; $display("FAIL zero_done: cycle %0d count %0d, required cycle %0d count 1", done_cyc, done_cnt, 1 + CK);
        end
        checks++;
        if (mem_rd_cnt !== 0 || busy_cnt !== 1 + CK) begin
            errors++; $display("FAIL zero_rd_busy: %0d reads %0d busy cycles, required 0 and %0d", mem_rd_cnt, busy_cnt, 1 + CK);
        end
        checks++;
        if (q_bytes.size() !== CK || (CK == 1 && q_bytes.size() == 1 && q_bytes[0] !== 8'h00)) begin
            errors++; $display("FAIL zero_bytes: got %0d bytes, required %0d", q_bytes.size(), CK);
        end
    endtask

    task automatic test_start_while_busy();
        int base;
        base = $urandom_range(0, 1023);
        for (int w = 0; w < 3; w++) mem[(base + w) % 1024] = $urandom;
        model_dump(base, 3);
        run_dump(base, 3, 0, 5, 0);
        checks++;
        if (q_bytes.size() !== 12 + CK || done_cnt !== 1 || mem_rd_cnt !== 3) begin
            errors++; $display("FAIL busy_start: %0d bytes %0d done %0d reads, required %0d, 1, 3",
                               q_bytes.size(), done_cnt, mem_rd_cnt, 12 + CK);
        end
        for (int i = 0; i < exp_bytes.size() && i < q_bytes.size(); i++) begin
            checks++;
            if (q_bytes[i] !== exp_bytes[i]) begin
                errors++; $display("FAIL busy_byte[%0d]: got %h, required %h", i, q_bytes[i], exp_bytes[i]);
            end
        end
    endtask

    task automatic test_abort();
        mem[5] = 32'h11223344;
        mem[6] = $urandom;
        run_dump(5, 2, 0, 0, 2);
        #1;
        checks++;
        if ({dump_if.mem_rd, dump_if.mem_addr, dump_if.out_valid, dump_if.out_data,
             dump_if.busy, dump_if.done} !== 22'd0 || done_cnt !== 0) begin
            errors++; $display("FAIL abort_idle: valid=%0b busy=%0b done_seen=%0d, required 0",
                               dump_if.out_valid, dump_if.busy, done_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_dump(5, 1);
        run_dump(5, 1, 0, 0, 0);
        checks++;
        if (q_bytes.size() !== exp_bytes.size() || done_cnt !== 1) begin
            errors++; $display("FAIL abort_redump: %0d bytes %0d done, required %0d and 1",
                               q_bytes.size(), done_cnt, exp_bytes.size());
        end
        for (int i = 0; i < exp_bytes.size() && i < q_bytes.size(); i++) begin
            checks++;
            if (q_bytes[i] !== exp_bytes[i] || q_byte_cyc[i] !== 3 + i) begin
                errors++; $display("FAIL abort_byte[%0d]: got %h at %0d, required %h at %0d",
                                   i, q_bytes[i], q_byte_cyc[i], exp_bytes[i], 3 + i);
            end
        end
    endtask

    task automatic test_random();
        int base, count;
        for (int t = 0; t < 8; t++) begin
            base  = $urandom_range(0, 1023);
            count = $urandom_range(1, 5);
            for (int w = 0; w < count; w++) mem[(base + w) % 1024] = $urandom;
            model_dump(base, count);
            run_dump(base, count, 2, 0, 0);
            checks++;
            if (q_bytes.size() !== exp_bytes.size() || done_cnt !== 1 || stall_err !== 0) begin
                errors++; $display("FAIL rand%0d_summary: %0d bytes %0d done %0d stalls, required %0d, 1, 0",
                                   t, q_bytes.size(), done_cnt, stall_err, exp_bytes.size());
            end
            for (int i = 0; i < exp_bytes.size() && i < q_bytes.size(); i++) begin
                checks++;
                if (q_bytes[i] !== exp_bytes[i]) begin
                    errors++; $display("FAIL rand%0d_byte[%0d]: got %h, required %h", t, i, q_bytes[i], exp_bytes[i]);
                end
            end
            for (int i = 0; i < exp_addrs.size() && i < q_addrs.size(); i++) begin
                checks++;
                if (q_addrs[i] !== exp_addrs[i]) begin
                    errors++; $display("FAIL rand%0d_addr[%0d]: got %h, required %h", t, i, q_addrs[i], exp_addrs[i]);
                end
            end
        end
    endtask

    initial begin
        dump_if.start      = 1'b0;
        dump_if.base_addr  = '0;
        dump_if.word_count = '0;
        dump_if.out_ready  = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = $urandom;
        test_reset();
        test_single_word();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_start_while_busy();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
